// File: rtl/dom_d2_rand_gen.sv
// -----------------------------------------------------------------------------
// dom_d2_rand_gen
//
// Fresh-randomness source for an array of second-order (three-share) DOM AND
// gates. A seeded 64-bit Fibonacci LFSR (x^64+x^63+x^61+x^60+1) is advanced
// K = 3*N_GATES steps per clock; the K feedback bits of one advance form the
// output word r, three bits per gate. After every (re)seed the LFSR runs a
// warm-up phase of WARMUP advances before words are handed out. A word is
// flagged with r_valid for exactly one cycle, so no bit is ever consumed twice.
//
// Parameters
//   N_GATES     number of downstream d=2 DOM gates (1..21)
//   WARMUP      LFSR advances after seed acceptance before RUN (0..255)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   seed        64-bit seed word (0 is replaced by 1)
//   seed_valid  seed offered
//   seed_ready  seed accepted when seed_valid & seed_ready (1 outside reset)
//   en          request a fresh word this cycle (honoured in RUN only)
//   r           randomness; r[3g+2:3g] feeds gate g
//   r_valid     r was refreshed at the last edge
//   busy        warm-up in progress
//
// State | meaning
// ------+--------------------------------------------------------------------
// IDLE  | unseeded after reset; en ignored, outputs quiet
// WARMUP| LFSR advances every cycle, r held, r_valid low
// RUN   | en=1 advances LFSR and publishes the advance bits; en=0 holds
// -----------------------------------------------------------------------------
module dom_d2_rand_gen #(
    parameter int N_GATES = 4,
    parameter int WARMUP  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [63:0]          seed,
    input  logic                 seed_valid,
    output logic                 seed_ready,
    input  logic                 en,
    output logic [3*N_GATES-1:0] r,
    output logic                 r_valid,
    output logic                 busy
);

    localparam int K     = 3 * N_GATES;
    // The counter is never consulted when WARMUP is 0; keep it one bit wide
    // so the declaration stays legal.
    localparam int CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP > 0) ? (WARMUP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t           state;
    logic [63:0]      lfsr_state;
    logic [63:0]      adv_state;
    logic [K-1:0]     adv_bits;
    logic [63:0]      seed_eff;
    logic [CNT_W-1:0] warm_cnt;
    logic             seed_acc;

    assign seed_acc = seed_valid & seed_ready;

    // The all-zero state is the LFSR's lock-up point.
    assign seed_eff = (seed == 64'h0) ? 64'h1 : seed;

    // K single steps unrolled. Step i's feedback bit lands in adv_bits[i],
    // so the first generated bit is the LSB of the word.
    always_comb begin
        adv_state = lfsr_state;
        adv_bits  = '0;
        for (int i = 0; i < K; i++) begin
            adv_bits[i] = adv_state[63] ^ adv_state[62] ^ adv_state[60] ^ adv_state[59];
            adv_state   = {adv_state[62:0], adv_bits[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            lfsr_state <= '0;
            r          <= '0;
            r_valid    <= 1'b0;
            busy       <= 1'b0;
            seed_ready <= 1'b0;
            warm_cnt   <= '0;
        end else begin
            seed_ready <= 1'b1;
            // A seed overrides everything, including a concurrent en in RUN.
            if (seed_acc) begin
                lfsr_state <= seed_eff;
                r          <= '0;
                r_valid    <= 1'b0;
                warm_cnt   <= '0;
                if (WARMUP == 0) begin
                    state <= ST_RUN;
                    busy  <= 1'b0;
                end else begin
                    state <= ST_WARMUP;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        r_valid <= 1'b0;
                    end
                    ST_WARMUP: begin
                        lfsr_state <= adv_state;
                        r_valid    <= 1'b0;
                        if (warm_cnt == WARM_LAST) begin
                            state <= ST_RUN;
                            busy  <= 1'b0;
                        end else begin
                            warm_cnt <= warm_cnt + CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (en) begin
                            lfsr_state <= adv_state;
                            r          <= adv_bits;
                            r_valid    <= 1'b1;
                        end else begin
                            r_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dom_d2_rand_gen.sv
// -----------------------------------------------------------------------------
// tb_dom_d2_rand_gen
//
// Two instances: dut_a (N_GATES=4, WARMUP=16) is followed cycle by cycle by a
// behavioural model that works on whole words and a warm-up countdown;
// dut_b (N_GATES=1, WARMUP=0) is checked against hand-derived values.
// -----------------------------------------------------------------------------
module tb_dom_d2_rand_gen;

    localparam int KA = 12;
    localparam int WA = 16;
    localparam int KB = 3;
    // Taps at bits 63, 62, 60, 59.
    localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

    logic          clk;
    logic          rst;
    logic [63:0]   a_seed, b_seed;
    logic          a_seed_valid, b_seed_valid;
    logic          a_en, b_en;
    logic          a_seed_ready, b_seed_ready;
    logic [KA-1:0] a_r;
    logic [KB-1:0] b_r;
    logic          a_r_valid, b_r_valid;
    logic          a_busy, b_busy;

    int checks = 0;
    int fails  = 0;

    // Reference model of dut_a.
    int            m_mode;       // 0 unseeded, 1 warming up, 2 running
    int            m_warm_left;
    logic          m_ready;
    logic [63:0]   m_s;
    logic [KA-1:0] m_r;
    logic          m_rv;

    dom_d2_rand_gen #(.N_GATES(4), .WARMUP(16)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .seed       (a_seed),
        .seed_valid (a_seed_valid),
        .seed_ready (a_seed_ready),
        .en         (a_en),
        .r          (a_r),
        .r_valid    (a_r_valid),
        .busy       (a_busy)
    );

    dom_d2_rand_gen #(.N_GATES(1), .WARMUP(0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .seed       (b_seed),
        .seed_valid (b_seed_valid),
        .seed_ready (b_seed_ready),
        .en         (b_en),
        .r          (b_r),
        .r_valid    (b_r_valid),
        .busy       (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic lfsr_fb(input logic [63:0] s);
        return ^(s & TAPS);
    endfunction

    task automatic model_reset();
        m_mode      = 0;
        m_warm_left = 0;
        m_ready     = 1'b0;
        m_s         = 64'h0;
        m_r         = '0;
        m_rv        = 1'b0;
    endtask

    task automatic model_edge(input logic sv, input logic [63:0] sd, input logic e);
        logic [KA-1:0] w;
        logic          fb;
        if (sv && m_ready) begin
            m_s         = (sd == 64'h0) ? 64'h1 : sd;
            m_r         = '0;
            m_rv        = 1'b0;
            m_warm_left = WA;
            m_mode      = (WA == 0) ? 2 : 1;
        end else if (m_mode == 1) begin
            for (int i = 0; i < KA; i++) begin
                fb  = lfsr_fb(m_s);
                m_s = (m_s << 1) | 64'(fb);
            end
            m_rv = 1'b0;
            m_warm_left--;
            if (m_warm_left == 0) m_mode = 2;
        end else if (m_mode == 2 && e) begin
            w = '0;
            for (int i = 0; i < KA; i++) begin
                fb   = lfsr_fb(m_s);
                w[i] = fb;
                m_s  = (m_s << 1) | 64'(fb);
            end
            m_r  = w;
            m_rv = 1'b1;
        end else begin
            m_rv = 1'b0;
        end
        m_ready = 1'b1;
    endtask

    task automatic check_a(input string tag);
        chk({tag, ".r"},          64'(a_r),          64'(m_r));
        chk({tag, ".r_valid"},    64'(a_r_valid),    64'(m_rv));
        chk({tag, ".busy"},       64'(a_busy),       64'(m_mode == 1));
        chk({tag, ".seed_ready"}, 64'(a_seed_ready), 64'(m_ready));
        chk({tag, ".lfsr"},       dut_a.lfsr_state,  m_s);
    endtask

    task automatic cycle_a(input logic sv, input logic [63:0] sd, input logic e, input string tag);
        a_seed_valid = sv;
        a_seed       = sd;
        a_en         = e;
        @(posedge clk);
        #1;
        model_edge(sv, sd, e);
        check_a(tag);
    endtask

    initial begin
        int busy_cycles;
        int first_valid;
        logic sv;
        logic [63:0] sd;

        rst = 1'b0;
        a_seed = '0; a_seed_valid = 1'b0; a_en = 1'b0;
        b_seed = '0; b_seed_valid = 1'b0; b_en = 1'b0;
        model_reset();

        // Reset values
        #2 rst = 1'b1;
        #1;
        check_a("reset");
        chk("reset_b.r",          64'(b_r),          64'h0);
        chk("reset_b.seed_ready", 64'(b_seed_ready), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        check_a("reset_held");
        #2 rst = 1'b0;

        // No seed, en high: nothing happens
        b_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle_a(1'b0, 64'h0, 1'b1, "idle");
            chk("idle_b.r",          64'(b_r),          64'h0);
            chk("idle_b.r_valid",    64'(b_r_valid),    64'h0);
            chk("idle_b.busy",       64'(b_busy),       64'h0);
            chk("idle_b.seed_ready", 64'(b_seed_ready), 64'h1);
        end

        // N_GATES=1, WARMUP=0 known-answer sequence
        b_seed = 64'h8000_0000_0000_0000; b_seed_valid = 1'b1; b_en = 1'b1;
        cycle_a(1'b0, 64'h0, 1'b0, "b_phase");
        chk("kat_acc.r",       64'(b_r),         64'h0);
        chk("kat_acc.r_valid", 64'(b_r_valid),   64'h0);
        chk("kat_acc.busy",    64'(b_busy),      64'h0);
        chk("kat_acc.lfsr",    dut_b.lfsr_state, 64'h8000_0000_0000_0000);
        b_seed_valid = 1'b0;
        cycle_a(1'b0, 64'h0, 1'b0, "b_phase");
        chk("kat_t1.r",        64'(b_r),         64'h1);
        chk("kat_t1.r_valid",  64'(b_r_valid),   64'h1);
        chk("kat_t1.lfsr",     dut_b.lfsr_state, 64'h4);
        cycle_a(1'b0, 64'h0, 1'b0, "b_phase");
        chk("kat_t2.r",        64'(b_r),         64'h0);
        chk("kat_t2.r_valid",  64'(b_r_valid),   64'h1);
        chk("kat_t2.lfsr",     dut_b.lfsr_state, 64'h20);
        b_en = 1'b0;
        cycle_a(1'b0, 64'h0, 1'b0, "b_phase");
        chk("kat_hold.r_valid", 64'(b_r_valid),   64'h0);
        chk("kat_hold.lfsr",    dut_b.lfsr_state, 64'h20);
        b_en = 1'b1;
        cycle_a(1'b0, 64'h0, 1'b0, "b_phase");
        chk("kat_t3.r_valid",  64'(b_r_valid),   64'h1);
        chk("kat_t3.lfsr",     dut_b.lfsr_state, 64'h100);
        b_en = 1'b0;

        // Seed 0 (treated as 1): warm-up length and first-valid latency
        cycle_a(1'b1, 64'h0, 1'b1, "seed0_acc");
        busy_cycles = a_busy ? 1 : 0;
        first_valid = -1;
        for (int k = 1; k <= 30; k++) begin
            cycle_a(1'b0, 64'h0, 1'b1, "seed0_run");
            if (a_busy) busy_cycles++;
            if (a_r_valid && first_valid < 0) first_valid = k;
        end
        chk("seed0.busy_cycles", 64'(busy_cycles), 64'd16);
        chk("seed0.first_valid", 64'(first_valid), 64'd17);

        // Seed 1: same stream as seed 0 via the model
        cycle_a(1'b1, 64'h1, 1'b0, "seed1_acc");
        for (int k = 0; k < 16; k++) cycle_a(1'b0, 64'h0, 1'($urandom_range(1)), "seed1_warm");
        for (int k = 0; k < 10; k++) cycle_a(1'b0, 64'h0, 1'b1, "seed1_run");

        // en toggled 1,0,0,1
        cycle_a(1'b0, 64'h0, 1'b1, "toggle_1a");
        cycle_a(1'b0, 64'h0, 1'b0, "toggle_0a");
        cycle_a(1'b0, 64'h0, 1'b0, "toggle_0b");
        cycle_a(1'b0, 64'h0, 1'b1, "toggle_1b");

        // Random en with occasional random reseeds
        for (int k = 0; k < 80; k++) begin
            sv = ($urandom_range(24) == 0);
            sd = ($urandom_range(3) == 0) ? 64'h0 : {$urandom(), $urandom()};
            cycle_a(sv, sd, 1'($urandom_range(1)), "random");
        end

        // Reseed on the same edge as en=1 while in RUN
        for (int k = 0; k < 20; k++) cycle_a(1'b0, 64'h0, 1'b1, "pre_reseed");
        cycle_a(1'b1, 64'hDEAD_BEEF_0123_4567, 1'b1, "reseed_en");
        chk("reseed_en.r_exact",       64'(a_r),       64'h0);
        chk("reseed_en.r_valid_exact", 64'(a_r_valid), 64'h0);
        chk("reseed_en.busy_exact",    64'(a_busy),    64'h1);
        for (int k = 0; k < 16; k++) cycle_a(1'b0, 64'h0, 1'b1, "reseed_warm");
        for (int k = 0; k < 8; k++)  cycle_a(1'b0, 64'h0, 1'($urandom_range(1)), "reseed_run");

        // Reset asserted in cycle 5 of warm-up
        cycle_a(1'b1, 64'h0F0F_1234_5678_9ABC, 1'b0, "seed3_acc");
        for (int k = 0; k < 4; k++) cycle_a(1'b0, 64'h0, 1'b1, "seed3_warm");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_a("rst_mid_warm");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) cycle_a(1'b0, 64'h0, 1'b1, "post_rst");

        a_en = 1'b0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
